// File: rtl/e_stage_reg.sv
// Decode-to-Execute pipeline register with NOP-bubble injection on mispredict or load/use.
// Optional saturating bubble counters are built when E_PERF_CNT_EN is defined.
module e_stage_reg #(
  parameter int unsigned W  = 64,
  parameter int unsigned CW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    d_stat,
  input  logic [3:0]    d_icode,
  input  logic [3:0]    d_ifun,
  input  logic [W-1:0]  d_valC,
  input  logic [W-1:0]  d_valA,
  input  logic [W-1:0]  d_valB,
  input  logic [3:0]    d_dstE,
  input  logic [3:0]    d_dstM,
  input  logic [3:0]    d_srcA,
  input  logic [3:0]    d_srcB,
  input  logic          e_cnd,
  output logic [3:0]    E_stat,
  output logic [3:0]    E_icode,
  output logic [3:0]    E_ifun,
  output logic [W-1:0]  E_valC,
  output logic [W-1:0]  E_valA,
  output logic [W-1:0]  E_valB,
  output logic [3:0]    E_dstE,
  output logic [3:0]    E_dstM,
  output logic [3:0]    E_srcA,
  output logic [3:0]    E_srcB,
  output logic          E_bubble,
  output logic          E_mispred,
  output logic          E_loaduse
`ifdef E_PERF_CNT_EN
  ,
  output logic [CW-1:0] cnt_mispred,
  output logic [CW-1:0] cnt_loaduse
`endif
);

  localparam logic [3:0] STAT_AOK     = 4'h1;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;
  localparam logic [3:0] RNONE        = 4'hF;

  logic [3:0]   r_stat, r_icode, r_ifun;
  logic [W-1:0] r_valC, r_valA, r_valB;
  logic [3:0]   r_dstE, r_dstM, r_srcA, r_srcB;
  logic         w_mispred, w_loaduse, w_bubble;

  // The RNONE guard on dstM also keeps d_srcA/d_srcB == RNONE from ever matching.
  always_comb begin
    w_mispred = (r_icode == ICODE_JXX) && !e_cnd;
    w_loaduse = ((r_icode == ICODE_MRMOVQ) || (r_icode == ICODE_POPQ)) &&
                (r_dstM != RNONE) &&
                ((r_dstM == d_srcA) || (r_dstM == d_srcB));
    w_bubble  = w_mispred | w_loaduse;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || w_bubble) begin
      if (!rst_n) begin
        r_stat  <= STAT_AOK;
        r_icode <= ICODE_NOP;
        r_ifun  <= '0;
        r_valC  <= '0;
        r_valA  <= '0;
        r_valB  <= '0;
        r_dstE  <= RNONE;
        r_dstM  <= RNONE;
        r_srcA  <= RNONE;
        r_srcB  <= RNONE;
      end else begin
        r_stat  <= STAT_AOK;
        r_icode <= ICODE_NOP;
        r_ifun  <= '0;
        r_valC  <= '0;
        r_valA  <= '0;
        r_valB  <= '0;
        r_dstE  <= RNONE;
        r_dstM  <= RNONE;
        r_srcA  <= RNONE;
        r_srcB  <= RNONE;
      end
    end else begin
      r_stat  <= d_stat;
      r_icode <= d_icode;
      r_ifun  <= d_ifun;
      r_valC  <= d_valC;
      r_valA  <= d_valA;
      r_valB  <= d_valB;
      r_dstE  <= d_dstE;
      r_dstM  <= d_dstM;
      r_srcA  <= d_srcA;
      r_srcB  <= d_srcB;
    end
  end

`ifdef E_PERF_CNT_EN
  logic [CW-1:0] r_cnt_mispred, r_cnt_loaduse;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_mispred <= '0;
      r_cnt_loaduse <= '0;
    end else begin
      if (w_mispred && (r_cnt_mispred != '1))
        r_cnt_mispred <= r_cnt_mispred + CW'(1);
      if (w_loaduse && (r_cnt_loaduse != '1))
        r_cnt_loaduse <= r_cnt_loaduse + CW'(1);
    end
  end

  assign cnt_mispred = r_cnt_mispred;
  assign cnt_loaduse = r_cnt_loaduse;
`endif

  assign E_stat    = r_stat;
  assign E_icode   = r_icode;
  assign E_ifun    = r_ifun;
  assign E_valC    = r_valC;
  assign E_valA    = r_valA;
  assign E_valB    = r_valB;
  assign E_dstE    = r_dstE;
  assign E_dstM    = r_dstM;
  assign E_srcA    = r_srcA;
  assign E_srcB    = r_srcB;
  assign E_bubble  = w_bubble;
  assign E_mispred = w_mispred;
  assign E_loaduse = w_loaduse;

endmodule

// File: tb/tb_e_stage_reg.sv
// Directed self-checking bench for e_stage_reg; counter scenarios run only when E_PERF_CNT_EN is defined.
module tb_e_stage_reg;

  localparam int unsigned W  = 64;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    d_stat, d_icode, d_ifun;
  logic [W-1:0]  d_valC, d_valA, d_valB;
  logic [3:0]    d_dstE, d_dstM, d_srcA, d_srcB;
  logic          e_cnd;
  logic [3:0]    E_stat, E_icode, E_ifun;
  logic [W-1:0]  E_valC, E_valA, E_valB;
  logic [3:0]    E_dstE, E_dstM, E_srcA, E_srcB;
  logic          E_bubble, E_mispred, E_loaduse;
`ifdef E_PERF_CNT_EN
  logic [CW-1:0] cnt_mispred, cnt_loaduse;
  logic [CW-1:0] c0;
`endif

  int checks = 0;
  int errors = 0;

  e_stage_reg #(.W(W), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun),
    .d_valC(d_valC), .d_valA(d_valA), .d_valB(d_valB),
    .d_dstE(d_dstE), .d_dstM(d_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .e_cnd(e_cnd),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
    .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB),
    .E_bubble(E_bubble), .E_mispred(E_mispred), .E_loaduse(E_loaduse)
`ifdef E_PERF_CNT_EN
    , .cnt_mispred(cnt_mispred), .cnt_loaduse(cnt_loaduse)
`endif
  );

  always #5 clk = ~clk;

  task automatic set_d(input logic [3:0] stat, input logic [3:0] icode, input logic [3:0] ifun,
                       input logic [W-1:0] valC, input logic [W-1:0] valA, input logic [W-1:0] valB,
                       input logic [3:0] dstE, input logic [3:0] dstM,
                       input logic [3:0] srcA, input logic [3:0] srcB);
    d_stat = stat; d_icode = icode; d_ifun = ifun;
    d_valC = valC; d_valA = valA; d_valB = valB;
    d_dstE = dstE; d_dstM = dstM; d_srcA = srcA; d_srcB = srcB;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    e_cnd = 1'b1;
    set_d(4'($urandom), 4'($urandom), 4'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
          {$urandom, $urandom}, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    step();
    step();
    checks++; if (E_icode !== 4'h1) begin errors++; $display("FAIL reset_icode got %h exp 1", E_icode); end
    checks++; if (E_stat !== 4'h1) begin errors++; $display("FAIL reset_stat got %h exp 1", E_stat); end
    checks++; if ({E_dstE, E_dstM, E_srcA, E_srcB} !== 16'hFFFF) begin errors++;
      $display("FAIL reset_regids got %h exp ffff", {E_dstE, E_dstM, E_srcA, E_srcB}); end
    checks++; if ({E_valA, E_valB, E_valC} !== '0) begin errors++;
      $display("FAIL reset_vals got %h/%h/%h exp 0", E_valA, E_valB, E_valC); end
    checks++; if (E_ifun !== 4'h0) begin errors++; $display("FAIL reset_ifun got %h exp 0", E_ifun); end
    checks++; if (E_bubble !== 1'b0) begin errors++; $display("FAIL reset_bubble got %b exp 0", E_bubble); end
`ifdef E_PERF_CNT_EN
    checks++; if ({cnt_mispred, cnt_loaduse} !== '0) begin errors++;
      $display("FAIL reset_cnt got %h/%h exp 0", cnt_mispred, cnt_loaduse); end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_pass_through();
    e_cnd = 1'b0;
    set_d(4'h1, 4'h6, 4'h0, 64'h9, 64'h5, 64'h7, 4'h3, 4'hF, 4'h1, 4'h2);
    step();
    checks++; if ({E_stat, E_icode, E_ifun} !== 12'h160) begin errors++;
      $display("FAIL pass_codes got %h exp 160", {E_stat, E_icode, E_ifun}); end
    checks++; if (E_valA !== 64'h5 || E_valB !== 64'h7 || E_valC !== 64'h9) begin errors++;
      $display("FAIL pass_vals got %h/%h/%h exp 5/7/9", E_valA, E_valB, E_valC); end
    checks++; if ({E_dstE, E_dstM, E_srcA, E_srcB} !== 16'h3F12) begin errors++;
      $display("FAIL pass_regids got %h exp 3f12", {E_dstE, E_dstM, E_srcA, E_srcB}); end
    set_d(4'h3, 4'h2, 4'h0, 64'hDEAD_BEEF_0123_4567, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 4'hA, 4'hF, 4'h4, 4'hF);
    step();
    checks++; if (E_stat !== 4'h3 || E_icode !== 4'h2) begin errors++;
      $display("FAIL pass_adr_stat got %h/%h exp 3/2", E_stat, E_icode); end
    checks++; if (E_valC !== 64'hDEAD_BEEF_0123_4567 || E_valA !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++;
      $display("FAIL pass_wide got %h/%h", E_valC, E_valA); end
  endtask

  task automatic test_mispredict();
`ifdef E_PERF_CNT_EN
    c0 = cnt_mispred;
`endif
    e_cnd = 1'b0;
    set_d(4'h1, 4'h7, 4'h2, 64'h100, 64'h0, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF);
    step();
    set_d(4'h1, 4'h6, 4'h1, 64'h0, 64'h11, 64'h22, 4'h4, 4'hF, 4'h1, 4'h2);
    #1;
    checks++; if (E_mispred !== 1'b1 || E_bubble !== 1'b1) begin errors++;
      $display("FAIL mispred_flag got m=%b b=%b exp 1/1", E_mispred, E_bubble); end
    step();
    checks++; if (E_icode !== 4'h1 || E_dstE !== 4'hF || E_valA !== '0) begin errors++;
      $display("FAIL mispred_bubble got icode=%h dstE=%h valA=%h exp 1/f/0", E_icode, E_dstE, E_valA); end
`ifdef E_PERF_CNT_EN
    checks++; if (cnt_mispred !== c0 + CW'(1)) begin errors++;
      $display("FAIL mispred_cnt got %0d exp %0d", cnt_mispred, c0 + CW'(1)); end
    c0 = cnt_mispred;
`endif
    set_d(4'h1, 4'h7, 4'h2, 64'h100, 64'h0, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF);
    step();
    e_cnd = 1'b1;
    set_d(4'h1, 4'h6, 4'h1, 64'h0, 64'h11, 64'h22, 4'h4, 4'hF, 4'h1, 4'h2);
    #1;
    checks++; if (E_mispred !== 1'b0 || E_bubble !== 1'b0) begin errors++;
      $display("FAIL taken_flag got m=%b b=%b exp 0/0", E_mispred, E_bubble); end
    step();
    checks++; if (E_icode !== 4'h6 || E_dstE !== 4'h4 || E_valB !== 64'h22) begin errors++;
      $display("FAIL taken_capture got icode=%h dstE=%h valB=%h exp 6/4/22", E_icode, E_dstE, E_valB); end
`ifdef E_PERF_CNT_EN
    checks++; if (cnt_mispred !== c0) begin errors++;
      $display("FAIL taken_cnt got %0d exp %0d", cnt_mispred, c0); end
`endif
  endtask

  task automatic test_loaduse();
`ifdef E_PERF_CNT_EN
    c0 = cnt_loaduse;
`endif
    e_cnd = 1'b0;
    set_d(4'h1, 4'h5, 4'h0, 64'h8, 64'h0, 64'h3, 4'hF, 4'h2, 4'hF, 4'h3);
    step();
    set_d(4'h1, 4'h6, 4'h0, 64'h0, 64'h1, 64'h2, 4'h6, 4'hF, 4'h2, 4'h7);
    #1;
    checks++; if (E_loaduse !== 1'b1 || E_bubble !== 1'b1 || E_mispred !== 1'b0) begin errors++;
      $display("FAIL loaduse_flag got l=%b b=%b m=%b exp 1/1/0", E_loaduse, E_bubble, E_mispred); end
    step();
    checks++; if (E_icode !== 4'h1 || E_dstM !== 4'hF || E_srcA !== 4'hF) begin errors++;
      $display("FAIL loaduse_bubble got icode=%h dstM=%h srcA=%h exp 1/f/f", E_icode, E_dstM, E_srcA); end
`ifdef E_PERF_CNT_EN
    checks++; if (cnt_loaduse !== c0 + CW'(1)) begin errors++;
      $display("FAIL loaduse_cnt got %0d exp %0d", cnt_loaduse, c0 + CW'(1)); end
    c0 = cnt_loaduse;
`endif
    set_d(4'h1, 4'h5, 4'h0, 64'h8, 64'h0, 64'h3, 4'hF, 4'h2, 4'hF, 4'h3);
    step();
    set_d(4'h1, 4'h6, 4'h0, 64'h0, 64'h1, 64'h2, 4'h5, 4'hF, 4'hF, 4'hF);
    #1;
    checks++; if (E_loaduse !== 1'b0 || E_bubble !== 1'b0) begin errors++;
      $display("FAIL rnone_flag got l=%b b=%b exp 0/0", E_loaduse, E_bubble); end
    step();
    checks++; if (E_icode !== 4'h6 || E_dstE !== 4'h5) begin errors++;
      $display("FAIL rnone_capture got icode=%h dstE=%h exp 6/5", E_icode, E_dstE); end
`ifdef E_PERF_CNT_EN
    checks++; if (cnt_loaduse !== c0) begin errors++;
      $display("FAIL rnone_cnt got %0d exp %0d", cnt_loaduse, c0); end
`endif
    set_d(4'h1, 4'hB, 4'h0, 64'h0, 64'h0, 64'h0, 4'h4, 4'h9, 4'h4, 4'h4);
    step();
    set_d(4'h1, 4'h6, 4'h0, 64'h0, 64'h1, 64'h2, 4'h5, 4'hF, 4'h1, 4'h9);
    #1;
    checks++; if (E_loaduse !== 1'b1) begin errors++;
      $display("FAIL popq_srcB got l=%b exp 1", E_loaduse); end
    step();
    checks++; if (E_icode !== 4'h1) begin errors++;
      $display("FAIL popq_bubble got icode=%h exp 1", E_icode); end
  endtask

  task automatic test_async_reset();
    e_cnd = 1'b1;
    set_d(4'h1, 4'hB, 4'h0, 64'h0, 64'h0, 64'h77, 4'h4, 4'h3, 4'h4, 4'h4);
    step();
    set_d(4'h1, 4'h6, 4'h0, 64'h0, 64'h1, 64'h2, 4'h7, 4'hF, 4'h3, 4'hF);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (E_icode !== 4'h1 || E_dstM !== 4'hF || E_valB !== '0 || E_bubble !== 1'b0) begin errors++;
      $display("FAIL async_image got icode=%h dstM=%h valB=%h b=%b exp 1/f/0/0", E_icode, E_dstM, E_valB, E_bubble); end
`ifdef E_PERF_CNT_EN
    checks++; if ({cnt_mispred, cnt_loaduse} !== '0) begin errors++;
      $display("FAIL async_cnt got %h/%h exp 0", cnt_mispred, cnt_loaduse); end
`endif
    #1;
    rst_n = 1'b1;
    step();
    checks++; if (E_icode !== 4'h6 || E_dstE !== 4'h7 || E_srcA !== 4'h3) begin errors++;
      $display("FAIL post_reset_capture got icode=%h dstE=%h srcA=%h exp 6/7/3", E_icode, E_dstE, E_srcA); end
  endtask

`ifdef E_PERF_CNT_EN
  task automatic test_saturation();
    e_cnd = 1'b0;
    set_d(4'h1, 4'h7, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF);
    c0 = cnt_mispred;
    for (int i = 1; i <= 20; i++) begin
      step();
      step();
      if (i == 15) begin
        checks++; if (cnt_mispred !== c0 + CW'(15)) begin errors++;
          $display("FAIL sat_reach got %0d exp %0d", cnt_mispred, c0 + CW'(15)); end
      end
    end
    checks++; if (cnt_mispred !== 4'hF) begin errors++;
      $display("FAIL sat_hold got %0d exp 15", cnt_mispred); end
  endtask
`endif

  initial begin
    test_reset();
    test_pass_through();
    test_mispredict();
    test_loaduse();
    test_async_reset();
`ifdef E_PERF_CNT_EN
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    test_saturation();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/e_stage_reg.md
# e_stage_reg

Decode-to-Execute pipeline register for the Y86-64 PIPE processor, with its own bubble control. Sits directly downstream of the F/D register and the decode logic. Captures decoded fields every cycle and injects a NOP bubble into Execute on a mispredicted jump or a load/use hazard. Optional saturating counters report how many bubbles each hazard class caused.

## Interface
Parameters:
- `W`, 64: data width of valC/valA/valB.
- `CW`, 32: performance counter width (used only with `E_PERF_CNT_EN`).

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `d_stat` in 4: status from decode (AOK=1, HLT=2, ADR=3, INS=4).
- `d_icode`, `d_ifun` in 4 each: instruction code and function code.
- `d_valC`, `d_valA`, `d_valB` in W: constant word and operand values, after forwarding.
- `d_dstE`, `d_dstM`, `d_srcA`, `d_srcB` in 4 each: register IDs; RNONE=4'hF.
- `e_cnd` in 1: condition outcome computed this cycle for the instruction currently held in E.
- `E_stat`, `E_icode`, `E_ifun` out 4 each: registered fields.
- `E_valC`, `E_valA`, `E_valB` out W: registered values.
- `E_dstE`, `E_dstM`, `E_srcA`, `E_srcB` out 4 each: registered register IDs.
- `E_bubble` out 1: combinational; high when the next edge loads a bubble.
- `E_mispred` out 1: combinational; `E_icode==4'h7 && !e_cnd`.
- `E_loaduse` out 1: combinational; `(E_icode==4'h5 || E_icode==4'hB) && E_dstM!=4'hF && (E_dstM==d_srcA || E_dstM==d_srcB)`.
- `cnt_mispred`, `cnt_loaduse` out CW: bubble counters (present only with `E_PERF_CNT_EN`).

## Operation
- `E_bubble = E_mispred | E_loaduse`. The E register never stalls.
- Rising edge with `E_bubble=0`: every E output takes its d_ counterpart.
- Rising edge with `E_bubble=1`: load the bubble image:
  - stat=1 (AOK), icode=4'h1 (NOP), ifun=0
  - valC, valA, valB = 0
  - dstE, dstM, srcA, srcB = 4'hF
- Reset value of every E output is the bubble image. Counters reset to 0.
- When both hazard terms are high at once, which cannot happen because E_icode differs between them, the result is still a single bubble. In that case both counters increment.
- `d_srcA==4'hF` or `d_srcB==4'hF` never produces a load/use match; the RNONE guard on E_dstM enforces this.
- The status field passes through unchanged. A non-AOK `d_stat` is captured like any other field unless bubbled.

## Timing
- Latency of 1 cycle, d_ to E_.
- Bubble decisions use the E contents and `e_cnd` in the same cycle. They take effect at the next edge.
- The three combinational outputs have no register stage.
- An asynchronous `rst_n` assertion clears all state immediately, including mid-hazard. The first edge after deassertion captures d_ inputs, subject to the bubble rule evaluated on the reset image. The reset image is a NOP, so that edge never bubbles.
- Counters increment on the same edge that loads the bubble. They saturate at all-ones and do not wrap.

## Configuration
- `E_PERF_CNT_EN` defined:
  - `cnt_mispred` increments on every edge where `E_mispred=1`.
  - `cnt_loaduse` increments on every edge where `E_loaduse=1`.
  - Both are CW bits wide and saturate.
- `E_PERF_CNT_EN` undefined: the counter ports and logic are absent. All other behaviour is identical.

## Test plan
- Reset check: hold rst_n=0 with random d_ inputs. Required: E_icode=1, E_stat=1, E_dstE=E_dstM=E_srcA=E_srcB=F, E_valA=0, E_bubble=0.
- Pass-through: capture d_icode=6, d_ifun=0, d_valA=5, d_valB=7, d_dstE=3. Required: identical values on E_ one cycle later.
- Mispredict: E holds icode=7 and e_cnd=0. Required: E_bubble=1, next E_icode=1, E_dstE=F, cnt_mispred +1. Repeat with e_cnd=1: normal capture, no increment.
- Load/use: E holds icode=5 with E_dstM=2, and d_srcA=2. Required: bubble loaded, cnt_loaduse +1. Same setup with E_dstM=2 and d_srcA=d_srcB=F: capture, no bubble.
- Async reset mid-stream: drop rst_n between edges while E holds icode=B. Required: outputs return to the bubble image immediately and both counters go to 0.
- Saturation (CW=4): force 20 consecutive mispredicts. Required: cnt_mispred stops at 15.
